// File: rtl/rr_arb_lock_pkg.sv
// rtl/rr_arb_lock_pkg.sv - shared types and helpers for the rr_arb_lock arbiter
//
// Purpose: the state enum, the index-width helper and the one-hot to binary
//          conversion used by the arbiter.
// Contents:
//   clog2w(n)    max(1, $clog2(n)); keeps index vectors at least one bit wide
//   arb_state_t  ARB (free to arbitrate) / LOCKED (held for a multi-flit packet)
//   oh2bin(oh)   binary index of a one-hot vector of up to 32 bits; 0 when empty

package arb_pkg;

   function automatic int clog2w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // ORs together the indices of the set bits. For a one-hot input this is the
   // index of that bit, and for an all-zero input it is 0.
   function automatic logic [4:0] oh2bin(input logic [31:0] oh);
      logic [4:0] bin;
      bin = '0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) begin
            bin = bin | 5'(i);
         end
      end
      return bin;
   endfunction

endpackage

// File: rtl/rr_arb_lock_prio_enc.sv
// rtl/rr_arb_lock_prio_enc.sv - lowest-index fixed-priority encoder
//
// Purpose: selects the lowest set bit of req_i.
// Ports:
//   req_i    in   IN_N  candidate requests
//   oh_o     out  IN_N  one-hot lowest set bit of req_i; zero when req_i is zero
//   found_o  out  1     req_i has at least one bit set

module prio_enc #(
   parameter int IN_N = 5
) (
   input  logic [IN_N-1:0] req_i,
   output logic [IN_N-1:0] oh_o,
   output logic            found_o
);

   always_comb begin
      oh_o    = '0;
      found_o = 1'b0;
      for (int i = 0; i < IN_N; i++) begin
         if (req_i[i] && !found_o) begin
            oh_o[i] = 1'b1;
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arb_lock.sv
// rtl/rr_arb_lock.sv - work-conserving round-robin arbiter with packet lock
//
// Purpose: grants one of IN_N requesters to a switch output port. The priority
//          pointer moves to the last winner, so the search always starts just
//          above it. Idle inputs are skipped in the same cycle. With LOCK_EN=1,
//          a grant is held on its owner until the tail flit has been accepted.
// Ports:
//   clk_i        in   1       clock
//   rst_ni       in   1       asynchronous active-low reset
//   req_i        in   IN_N    per-input request (level, N-hot)
//   last_i       in   IN_N    per-input tail flag, used only for the granted input
//   ack_i        in   1       downstream accepts the granted flit this cycle
//   grant_oh_o   out  IN_N    one-hot grant, zero when grant_vld_o=0
//   grant_o      out  IDX_W   binary index of grant_oh_o, 0 when no grant
//   grant_vld_o  out  1       a grant is valid this cycle
//   locked_o     out  1       arbiter is held on an owner mid-packet

module rr_arb_lock
   import arb_pkg::*;
#(
   parameter int IN_N    = 5,
   parameter int LOCK_EN = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [IN_N-1:0]           req_i,
   input  logic [IN_N-1:0]           last_i,
   input  logic                      ack_i,
   output logic [IN_N-1:0]           grant_oh_o,
   output logic [clog2w(IN_N)-1:0]   grant_o,
   output logic                      grant_vld_o,
   output logic                      locked_o
);

   localparam int IDX_W = clog2w(IN_N);

   logic [IDX_W-1:0] ptr_q,   ptr_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   arb_state_t       state_q, state_d;

   logic [IN_N-1:0]  above_ptr;
   logic [IN_N-1:0]  masked_req;
   logic [IN_N-1:0]  masked_oh;
   logic [IN_N-1:0]  unmasked_oh;
   logic             masked_found;
   logic             unmasked_found;
   logic [IN_N-1:0]  rr_oh;
   logic [IN_N-1:0]  owner_oh;
   logic [31:0]      grant_wide;
   logic             tail_hit;
   logic             transfer;

   // Bits strictly above the pointer. When ptr=IN_N-1 the mask is empty and the
   // unmasked encoder restarts the search from index 0.
   always_comb begin
      above_ptr = '0;
      owner_oh  = '0;
      for (int i = 0; i < IN_N; i++) begin
         above_ptr[i] = (i > int'(ptr_q));
         owner_oh[i]  = (owner_q == IDX_W'(i));
      end
   end

   assign masked_req = req_i & above_ptr;

   prio_enc #(.IN_N(IN_N)) u_enc_masked (
      .req_i   (masked_req),
      .oh_o    (masked_oh),
      .found_o (masked_found)
   );

   prio_enc #(.IN_N(IN_N)) u_enc_unmasked (
      .req_i   (req_i),
      .oh_o    (unmasked_oh),
      .found_o (unmasked_found)
   );

   assign rr_oh = masked_found ? masked_oh : unmasked_oh;

   // While locked, only the owner's request can produce a grant. Requests from
   // other inputs are ignored even when the owner has dropped its request.
   always_comb begin
      if (state_q == LOCKED) begin
         grant_oh_o  = req_i & owner_oh;
         grant_vld_o = |(req_i & owner_oh);
      end else begin
         grant_oh_o  = rr_oh;
         grant_vld_o = unmasked_found;
      end
   end

   always_comb begin
      grant_wide             = '0;
      grant_wide[IN_N-1:0]   = grant_oh_o;
   end

   assign grant_o  = IDX_W'(oh2bin(grant_wide));
   assign transfer = grant_vld_o & ack_i;
   // The grant is one-hot on the winner, or on the owner while locked, so this
   // picks out the tail flag of exactly the input being served.
   assign tail_hit = |(last_i & grant_oh_o);
   assign locked_o = (state_q == LOCKED);

   always_comb begin
      ptr_d   = ptr_q;
      owner_d = owner_q;
      state_d = state_q;
      if (transfer) begin
         ptr_d = grant_o;
         case (state_q)
            ARB: begin
               if ((LOCK_EN != 0) && !tail_hit) begin
                  state_d = LOCKED;
                  owner_d = grant_o;
               end
            end
            LOCKED: begin
               if (tail_hit) begin
                  state_d = ARB;
               end
            end
            default: state_d = ARB;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q   <= IDX_W'(IN_N - 1);
         owner_q <= '0;
         state_q <= ARB;
      end else begin
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         state_q <= state_d;
      end
   end

endmodule

// File: tb/tb_rr_arb_lock.sv
// tb/tb_rr_arb_lock.sv - directed self-checking bench for rr_arb_lock

module tb_rr_arb_lock;

   localparam int IN_N = 5;

   logic            clk_i;
   logic            rst_ni;
   logic [IN_N-1:0] req_i;
   logic [IN_N-1:0] last_i;
   logic            ack_i;
   logic [IN_N-1:0] grant_oh_o;
   logic [2:0]      grant_o;
   logic            grant_vld_o;
   logic            locked_o;

   int n_checks;
   int n_errors;

   rr_arb_lock #(.IN_N(IN_N), .LOCK_EN(1)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_i       (req_i),
      .last_i      (last_i),
      .ack_i       (ack_i),
      .grant_oh_o  (grant_oh_o),
      .grant_o     (grant_o),
      .grant_vld_o (grant_vld_o),
      .locked_o    (locked_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      int e1 [5];
      e1 = '{0, 2, 4, 0, 2};
      n_checks = 0;
      n_errors = 0;
      rst_ni = 1'b0;
      req_i  = '0;
      last_i = '0;
      ack_i  = 1'b0;
      #1;
      chk("rst_vld",    32'(grant_vld_o), 32'd0);
      chk("rst_grant",  32'(grant_o),     32'd0);
      chk("rst_oh",     32'(grant_oh_o),  32'd0);
      chk("rst_locked", 32'(locked_o),    32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();

      // 1: rotation over 0,2,4 starting at input 0
      req_i  = 5'b10101;
      last_i = 5'b11111;
      ack_i  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         chk("t1_grant", 32'(grant_o), 32'(e1[i]));
         chk("t1_vld",   32'(grant_vld_o), 32'd1);
         tick();
      end

      // 2: single requester served every cycle
      req_i = 5'b01000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("t2_grant", 32'(grant_o),    32'd3);
         chk("t2_oh",    32'(grant_oh_o), 32'h08);
         chk("t2_vld",   32'(grant_vld_o), 32'd1);
         tick();
      end

      // 3: three-flit packet on input 0 holds off input 1
      req_i  = 5'b00011;
      last_i = 5'b11110;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) last_i = 5'b11111;
         @(negedge clk_i);
         chk("t3_grant", 32'(grant_o), 32'd0);
         tick();
         chk("t3_locked", 32'(locked_o), (i < 2) ? 32'd1 : 32'd0);
      end
      ack_i = 1'b0;
      @(negedge clk_i);
      chk("t3_next", 32'(grant_o), 32'd1);
      tick();

      // 4: no ack holds the pointer; one ack moves it
      req_i = 5'b00110;
      ack_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("t4_hold", 32'(grant_o), 32'd1);
         tick();
      end
      ack_i = 1'b1;
      @(negedge clk_i);
      chk("t4_ackgrant", 32'(grant_o), 32'd1);
      tick();
      ack_i = 1'b0;
      @(negedge clk_i);
      chk("t4_after", 32'(grant_o), 32'd2);
      tick();

      // 5: owner drops its request while locked; input 4 must wait
      req_i  = 5'b00001;
      last_i = 5'b00000;
      ack_i  = 1'b1;
      @(negedge clk_i);
      chk("t5_first", 32'(grant_o), 32'd0);
      tick();
      chk("t5_locked", 32'(locked_o), 32'd1);
      req_i = 5'b10000;
      @(negedge clk_i);
      chk("t5_novld", 32'(grant_vld_o), 32'd0);
      chk("t5_nooh",  32'(grant_oh_o),  32'd0);
      tick();
      chk("t5_still", 32'(locked_o), 32'd1);
      req_i  = 5'b10001;
      last_i = 5'b00001;
      @(negedge clk_i);
      chk("t5_tail", 32'(grant_o), 32'd0);
      tick();
      ack_i = 1'b0;
      chk("t5_unlock", 32'(locked_o), 32'd0);
      @(negedge clk_i);
      chk("t5_then4", 32'(grant_o), 32'd4);
      tick();

      // 6: asynchronous reset while locked on input 3
      req_i  = 5'b01001;
      last_i = 5'b00000;
      ack_i  = 1'b1;
      @(negedge clk_i);
      chk("t6_grant", 32'(grant_o), 32'd3);
      tick();
      ack_i = 1'b0;
      chk("t6_locked", 32'(locked_o), 32'd1);
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      chk("t6_rstlock", 32'(locked_o), 32'd0);
      #2;
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("t6_grant0", 32'(grant_o),     32'd0);
      chk("t6_vld",    32'(grant_vld_o), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
